// File: rtl/lcd_init_fill.sv
// ST7789 power-on sequencer: reset timing, command table, full-screen fill, then idle.
// Define LCD_WINDOW_FILL_EN to accept window-fill requests from IDLE.
module lcd_init_fill #(
   parameter int unsigned H_RES      = 240,
   parameter int unsigned V_RES      = 320,
   parameter logic [22:0] T_RST      = 23'd5000_000,
   parameter logic [22:0] T_WAKE     = 23'd2500_000,
   parameter logic [22:0] T_SLPOUT   = 23'd6000_000,
   parameter logic [15:0] INIT_COLOR = 16'hFFFF
) (
   input  logic        sys_clk_50MHz,
   input  logic        sys_rst,
   input  logic        wr_done,
   input  logic        fill_req,
   input  logic [15:0] fill_color,
   input  logic [15:0] x0,
   input  logic [15:0] x1,
   input  logic [15:0] y0,
   input  logic [15:0] y1,
   output logic        lcd_rst,
   output logic [8:0]  init_data,
   output logic        en_write,
   output logic        init_done,
   output logic        fill_done
);

   localparam int unsigned PW      = $clog2(2 * H_RES * V_RES + 1);
   localparam int unsigned CMD_LEN = 58;
   localparam int unsigned WIN_LEN = 11;
   localparam logic [15:0] X_MAX   = 16'(H_RES - 1);
   localparam logic [15:0] Y_MAX   = 16'(V_RES - 1);

   typedef enum logic [2:0] {RST_LOW, WAKE, CMD, SLP_WAIT, WINDOW, PIXEL, IDLE} state_t;

   state_t         state_q, state_d;
   logic [22:0]    cnt_q, cnt_d;
   logic [5:0]     idx_q, idx_d;
   logic [PW-1:0]  pix_q, pix_d;
   logic [PW-1:0]  pix_last_c;
   logic [15:0]    wx0_q, wx0_d, wx1_q, wx1_d, wy0_q, wy0_d, wy1_q, wy1_d;
   logic [15:0]    color_q, color_d;
   logic           user_q, user_d;
   logic           lcd_rst_q, lcd_rst_d;
   logic [8:0]     init_data_q, init_data_d;
   logic           en_write_q, en_write_d;
   logic           init_done_q, init_done_d;
   logic           fill_done_q, fill_done_d;

   // ST7789 bring-up table; bit8 marks a data byte.
   function automatic logic [8:0] cmd_word(input logic [5:0] i);
      logic [8:0] w;
      case (i)
         6'd0:  w = 9'h011;
         6'd1:  w = 9'h036;  6'd2:  w = 9'h108;
         6'd3:  w = 9'h03A;  6'd4:  w = 9'h105;
         6'd5:  w = 9'h0B2;  6'd6:  w = 9'h10C;  6'd7:  w = 9'h10C;
         6'd8:  w = 9'h100;  6'd9:  w = 9'h133;  6'd10: w = 9'h133;
         6'd11: w = 9'h0B7;  6'd12: w = 9'h135;
         6'd13: w = 9'h0BB;  6'd14: w = 9'h119;
         6'd15: w = 9'h0C0;  6'd16: w = 9'h12C;
         6'd17: w = 9'h0C2;  6'd18: w = 9'h101;
         6'd19: w = 9'h0C3;  6'd20: w = 9'h112;
         6'd21: w = 9'h0C4;  6'd22: w = 9'h120;
         6'd23: w = 9'h0D0;  6'd24: w = 9'h1A4;  6'd25: w = 9'h1A1;
         6'd26: w = 9'h0E0;
         6'd27: w = 9'h1D0;  6'd28: w = 9'h104;  6'd29: w = 9'h10D;  6'd30: w = 9'h111;
         6'd31: w = 9'h113;  6'd32: w = 9'h12B;  6'd33: w = 9'h13F;  6'd34: w = 9'h154;
         6'd35: w = 9'h14C;  6'd36: w = 9'h118;  6'd37: w = 9'h10D;  6'd38: w = 9'h10B;
         6'd39: w = 9'h11F;  6'd40: w = 9'h123;
         6'd41: w = 9'h0E1;
         6'd42: w = 9'h1D0;  6'd43: w = 9'h104;  6'd44: w = 9'h10C;  6'd45: w = 9'h111;
         6'd46: w = 9'h113;  6'd47: w = 9'h12C;  6'd48: w = 9'h13F;  6'd49: w = 9'h144;
         6'd50: w = 9'h151;  6'd51: w = 9'h12F;  6'd52: w = 9'h11F;  6'd53: w = 9'h11F;
         6'd54: w = 9'h120;  6'd55: w = 9'h123;
         6'd56: w = 9'h021;  6'd57: w = 9'h029;
         default: w = 9'h000;
      endcase
      return w;
   endfunction

   function automatic logic [8:0] win_word(input logic [5:0] i, input logic [15:0] a0,
                                           input logic [15:0] a1, input logic [15:0] b0,
                                           input logic [15:0] b1);
      logic [8:0] w;
      case (i)
         6'd0:  w = 9'h02A;
         6'd1:  w = {1'b1, a0[15:8]};
         6'd2:  w = {1'b1, a0[7:0]};
         6'd3:  w = {1'b1, a1[15:8]};
         6'd4:  w = {1'b1, a1[7:0]};
         6'd5:  w = 9'h02B;
         6'd6:  w = {1'b1, b0[15:8]};
         6'd7:  w = {1'b1, b0[7:0]};
         6'd8:  w = {1'b1, b1[15:8]};
         6'd9:  w = {1'b1, b1[7:0]};
         6'd10: w = 9'h02C;
         default: w = 9'h000;
      endcase
      return w;
   endfunction

   function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign pix_last_c = PW'((32'(wx1_q - wx0_q) + 32'd1) * (32'(wy1_q - wy0_q) + 32'd1)
                           * 32'd2 - 32'd1);

`ifndef LCD_WINDOW_FILL_EN
   logic unused_fill;
   assign unused_fill = ^{fill_req, fill_color, x0, x1, y0, y1};
`endif

   // Next state, counters, window latch and registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      idx_d       = idx_q;
      pix_d       = pix_q;
      wx0_d       = wx0_q;
      wx1_d       = wx1_q;
      wy0_d       = wy0_q;
      wy1_d       = wy1_q;
      color_d     = color_q;
      user_d      = user_q;
      fill_done_d = 1'b0;

      case (state_q)
         RST_LOW: begin
            cnt_d = cnt_q + 23'd1;
            if (cnt_q == T_RST - 23'd1) state_d = WAKE;
         end
         WAKE: begin
            cnt_d = cnt_q + 23'd1;
            if (cnt_q == T_WAKE - 23'd1) state_d = CMD;
         end
         CMD: begin
            if (wr_done) begin
               if (idx_q == 6'(CMD_LEN - 1)) state_d = SLP_WAIT;
               else                          idx_d   = idx_q + 6'd1;
            end
         end
         SLP_WAIT: begin
            cnt_d = cnt_q + 23'd1;
            if (cnt_q == T_SLPOUT - 23'd1) begin
               state_d = WINDOW;
               wx0_d   = '0;
               wx1_d   = X_MAX;
               wy0_d   = '0;
               wy1_d   = Y_MAX;
               color_d = INIT_COLOR;
               user_d  = 1'b0;
            end
         end
         WINDOW: begin
            if (wr_done) begin
               if (idx_q == 6'(WIN_LEN - 1)) state_d = PIXEL;
               else                          idx_d   = idx_q + 6'd1;
            end
         end
         PIXEL: begin
            if (wr_done) begin
               if (pix_q == pix_last_c) begin
                  state_d     = IDLE;
                  fill_done_d = user_q;
               end else begin
                  pix_d = pix_q + PW'(1);
               end
            end
         end
         IDLE: begin
`ifdef LCD_WINDOW_FILL_EN
            if (fill_req) begin
               wx0_d   = clamp16((x1 < x0) ? x1 : x0, X_MAX);
               wx1_d   = clamp16((x1 < x0) ? x0 : x1, X_MAX);
               wy0_d   = clamp16((y1 < y0) ? y1 : y0, Y_MAX);
               wy1_d   = clamp16((y1 < y0) ? y0 : y1, Y_MAX);
               color_d = fill_color;
               user_d  = 1'b1;
               state_d = WINDOW;
            end
`endif
         end
         default: state_d = RST_LOW;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
         idx_d = '0;
         pix_d = '0;
      end

      lcd_rst_d   = (state_d != RST_LOW);
      en_write_d  = (state_d == CMD) || (state_d == WINDOW) || (state_d == PIXEL);
      init_done_d = (state_d == IDLE);
      case (state_d)
         CMD:     init_data_d = cmd_word(idx_d);
         WINDOW:  init_data_d = win_word(idx_d, wx0_d, wx1_d, wy0_d, wy1_d);
         PIXEL:   init_data_d = {1'b1, pix_d[0] ? color_d[7:0] : color_d[15:8]};
         default: init_data_d = 9'h000;
      endcase
   end

   always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= RST_LOW;
         cnt_q       <= '0;
         idx_q       <= '0;
         pix_q       <= '0;
         wx0_q       <= '0;
         wx1_q       <= '0;
         wy0_q       <= '0;
         wy1_q       <= '0;
         color_q     <= '0;
         user_q      <= 1'b0;
         lcd_rst_q   <= 1'b0;
         init_data_q <= 9'h000;
         en_write_q  <= 1'b0;
         init_done_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pix_q       <= pix_d;
         wx0_q       <= wx0_d;
         wx1_q       <= wx1_d;
         wy0_q       <= wy0_d;
         wy1_q       <= wy1_d;
         color_q     <= color_d;
         user_q      <= user_d;
         lcd_rst_q   <= lcd_rst_d;
         init_data_q <= init_data_d;
         en_write_q  <= en_write_d;
         init_done_q <= init_done_d;
         fill_done_q <= fill_done_d;
      end
   end

   assign lcd_rst   = lcd_rst_q;
   assign init_data = init_data_q;
   assign en_write  = en_write_q;
   assign init_done = init_done_q;
   assign fill_done = fill_done_q;

endmodule

// File: tb/tb_lcd_init_fill.sv
// Directed bench for lcd_init_fill on a 4x3 panel with a 3-cycle SPI writer model.
module tb_lcd_init_fill;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        wr_done;
   logic        fill_req;
   logic [15:0] fill_color, x0, x1, y0, y1;
   logic        lcd_rst, en_write, init_done, fill_done;
   logic [8:0]  init_data;

   int n_total = 0;
   int n_bad   = 0;
   logic [8:0] log_q[$];

   logic [8:0] w_po [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02B,
                             9'h100, 9'h100, 9'h100, 9'h102, 9'h02C};
   logic [8:0] w_f1 [11] = '{9'h02A, 9'h100, 9'h101, 9'h100, 9'h102, 9'h02B,
                             9'h100, 9'h100, 9'h100, 9'h100, 9'h02C};
   logic [8:0] w_f2 [11] = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h103, 9'h02B,
                             9'h100, 9'h101, 9'h100, 9'h102, 9'h02C};

   lcd_init_fill #(
      .H_RES(4), .V_RES(3), .T_RST(23'd10), .T_WAKE(23'd15), .T_SLPOUT(23'd12),
      .INIT_COLOR(16'hFFFF)
   ) dut (
      .sys_clk_50MHz(clk), .sys_rst(sys_rst), .wr_done(wr_done), .fill_req(fill_req),
      .fill_color(fill_color), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .lcd_rst(lcd_rst), .init_data(init_data), .en_write(en_write),
      .init_done(init_done), .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   // SPI writer model: logs each new word and acks it 3 cycles later.
   initial begin
      int   wcnt;
      logic prev_en, prev_wd;
      wcnt = 0; prev_en = 1'b0; wr_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         prev_wd = wr_done;
         wr_done = 1'b0;
         if (sys_rst) begin
            wcnt = 0; prev_en = 1'b0;
         end else begin
            if (en_write && (!prev_en || prev_wd)) begin
               log_q.push_back(init_data);
               wcnt = 3;
            end else if (wcnt > 0) begin
               wcnt--;
               if (wcnt == 0) wr_done = 1'b1;
            end
            prev_en = en_write;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] logw(input int i);
      if (i < log_q.size()) return 32'(log_q[i]);
      return 32'hDEAD_BEEF;
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while (init_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "_reach_idle"}, 32'(init_done), 32'd1);
   endtask

   task automatic check_stream(input string tag, input logic [8:0] ew [11],
                               input logic [15:0] col, input int npix);
      logic [8:0] e;
      chk({tag, "_len"}, log_q.size(), 11 + npix);
      for (int i = 0; i < 11; i++) chk($sformatf("%s_win%0d", tag, i), logw(i), 32'(ew[i]));
      for (int i = 0; i < npix; i++) begin
         e = (i % 2 == 0) ? {1'b1, col[15:8]} : {1'b1, col[7:0]};
         chk($sformatf("%s_pix%0d", tag, i), logw(11 + i), 32'(e));
      end
   endtask

   // Releases reset (called at a negedge with reset held) and checks the whole power-on run.
   task automatic power_on_seq(input string tag);
      int n;
      logic f108, f105;
      log_q.delete();
      sys_rst = 1'b0;
      n = 0;
      while (lcd_rst === 1'b0 && n < 100) begin n++; @(negedge clk); end
      chk({tag, "_rst_low_len"}, n, 10);
      n = 0;
      while (en_write !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      chk({tag, "_wake_len"}, n, 15);
      n = 0;
      while (en_write === 1'b1 && n < 1000) begin n++; @(negedge clk); end
      chk({tag, "_cmd_end"}, 32'(en_write), 32'd0);
      chk({tag, "_cmd_count"}, log_q.size(), 58);
      chk({tag, "_cmd_first"}, logw(0), 32'h011);
      chk({tag, "_cmd_56"}, logw(56), 32'h021);
      chk({tag, "_cmd_last"}, logw(57), 32'h029);
      f108 = 1'b0; f105 = 1'b0;
      for (int i = 0; i < 58; i++) begin
         if (logw(i) == 32'h108) f108 = 1'b1;
         if (logw(i) == 32'h105) f105 = 1'b1;
      end
      chk({tag, "_madctl"}, 32'(f108), 32'd1);
      chk({tag, "_colmod"}, 32'(f105), 32'd1);
      chk({tag, "_slp_data"}, 32'(init_data), 32'h000);
      log_q.delete();
      n = 0;
      while (en_write !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      chk({tag, "_slp_len"}, n, 12);
      wait_idle(tag);
      chk({tag, "_po_fill_done"}, 32'(fill_done), 32'd0);
      chk({tag, "_idle_en"}, 32'(en_write), 32'd0);
      chk({tag, "_idle_data"}, 32'(init_data), 32'h000);
      chk({tag, "_idle_lcdrst"}, 32'(lcd_rst), 32'd1);
      check_stream({tag, "_po"}, w_po, 16'hFFFF, 24);
   endtask

   task automatic start_fill(input logic [15:0] c, input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] b0, input logic [15:0] b1);
      log_q.delete();
      fill_color = c; x0 = a0; x1 = a1; y0 = b0; y1 = b1;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   initial begin
      int   n;
      logic seen_en, seen_fd;
      sys_rst = 1'b1; fill_req = 1'b0; fill_color = '0;
      x0 = '0; x1 = '0; y0 = '0; y1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_lcd_rst", 32'(lcd_rst), 32'd0);
      chk("rst_en", 32'(en_write), 32'd0);
      chk("rst_data", 32'(init_data), 32'h000);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_fill_done", 32'(fill_done), 32'd0);

      power_on_seq("p1");
      @(negedge clk);

`ifdef LCD_WINDOW_FILL_EN
      start_fill(16'hF800, 16'd1, 16'd2, 16'd0, 16'd0);
      chk("f1_started", 32'(en_write), 32'd1);
      wait_idle("f1");
      chk("f1_fill_done", 32'(fill_done), 32'd1);
      check_stream("f1", w_f1, 16'hF800, 4);
      @(negedge clk);
      chk("f1_fd_pulse", 32'(fill_done), 32'd0);

      // Swapped/out-of-range bounds; a mid-fill request with new inputs must be dropped.
      start_fill(16'h07E0, 16'd5, 16'd2, 16'd2, 16'd1);
      repeat (2) @(negedge clk);
      fill_color = 16'h1234; x0 = 16'd0; x1 = 16'd3; y0 = 16'd0; y1 = 16'd2;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      wait_idle("f2");
      chk("f2_fill_done", 32'(fill_done), 32'd1);
      check_stream("f2", w_f2, 16'h07E0, 8);
      seen_en = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (en_write === 1'b1) seen_en = 1'b1;
      end
      chk("busy_req_ignored", 32'(seen_en), 32'd0);
`else
      fill_color = 16'hF800; x0 = 16'd1; x1 = 16'd2; y0 = 16'd0; y1 = 16'd0;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      seen_en = 1'b0; seen_fd = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (en_write === 1'b1) seen_en = 1'b1;
         if (fill_done === 1'b1) seen_fd = 1'b1;
         @(negedge clk);
      end
      chk("nofill_en", 32'(seen_en), 32'd0);
      chk("nofill_fd", 32'(seen_fd), 32'd0);
      chk("nofill_idle", 32'(init_done), 32'd1);
`endif

      // Reset during pixel word 10 of the power-on fill, then a full rerun.
      sys_rst = 1'b1;
      @(negedge clk);
      log_q.delete();
      sys_rst = 1'b0;
      n = 0;
      while (log_q.size() < 80 && n < 3000) begin @(negedge clk); n++; end
      chk("mid_pix_reached", 32'(log_q.size() >= 80), 32'd1);
      chk("mid_pix_en", 32'(en_write), 32'd1);
      sys_rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_lcd_rst", 32'(lcd_rst), 32'd0);
      chk("mid_rst_en", 32'(en_write), 32'd0);
      chk("mid_rst_data", 32'(init_data), 32'h000);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      chk("mid_rst_fill_done", 32'(fill_done), 32'd0);
      @(negedge clk);
      power_on_seq("p2");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_init_fill.md
LCD_INIT_FILL -- requirements
Module: lcd_init_fill

Interface
REQ-001 Parameter H_RES, default 240: panel width in pixels.
REQ-002 Parameter V_RES, default 320: panel height in pixels.
REQ-003 Parameter T_RST, default 23'd5000_000: lcd_rst low-hold time in clocks.
REQ-004 Parameter T_WAKE, default 23'd2500_000: wait after reset release, in clocks.
REQ-005 Parameter T_SLPOUT, default 23'd6000_000: wait after command table, in clocks.
REQ-006 Parameter INIT_COLOR, default 16'hFFFF: RGB565 colour of the power-on full-screen fill.
REQ-007 sys_clk_50MHz  in  1  single clock; all logic on its rising edge.
REQ-008 sys_rst  in  1  asynchronous, active-high reset.
REQ-009 wr_done  in  1  one-cycle pulse from the SPI writer; the current word has been sent.
REQ-010 fill_req  in  1  one-cycle request for a window fill.
REQ-011 fill_color  in  16  RGB565 colour for a window fill.
REQ-012 x0, x1  in  16 each  window column bounds, inclusive.
REQ-013 y0, y1  in  16 each  window row bounds, inclusive.
REQ-014 lcd_rst  out  1  panel reset, active-low.
REQ-015 init_data  out  9  bit8=1 data, bit8=0 command; bits[7:0] are the byte.
REQ-016 en_write  out  1  high while words are being issued.
REQ-017 init_done  out  1  high in IDLE only.
REQ-018 fill_done  out  1  one-cycle pulse when a requested window fill completes.

Function
REQ-019 The FSM SHALL have seven states: RST_LOW, WAKE, CMD, SLP_WAIT, WINDOW, PIXEL, IDLE.
REQ-020 RST_LOW, WAKE and SLP_WAIT SHALL each last exactly T_RST, T_WAKE and T_SLPOUT cycles respectively, using one counter that clears on every state change.
REQ-021 lcd_rst SHALL be 0 in RST_LOW and 1 from the first WAKE cycle until the next reset.
REQ-022 CMD SHALL issue a fixed 58-entry ST7789 table, ending with 0x021, 0x029 (MADCTL 0x108, COLMOD 0x105); the index advances on each wr_done, and CMD exits to SLP_WAIT on the wr_done of entry 57.
REQ-023 WINDOW SHALL issue 11 words, in order: 0x02A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], 0x02B, y0 hi, y0 lo, y1 hi, y1 lo, 0x02C. Data words have bit8 set.
REQ-024 PIXEL SHALL issue 2*(x1-x0+1)*(y1-y0+1) data words: even index = colour[15:8], odd index = colour[7:0].
REQ-025 The pixel counter width SHALL be $clog2(2*H_RES*V_RES+1).
REQ-026 After SLP_WAIT, the block SHALL run WINDOW then PIXEL with window (0,0)-(H_RES-1,V_RES-1) and colour INIT_COLOR, then enter IDLE without pulsing fill_done.
REQ-027 The block SHALL latch window bounds and colour in the cycle fill_req is sampled in IDLE, then go to WINDOW.
REQ-028 fill_req outside IDLE SHALL be ignored and not queued.
REQ-029 At latch time, if x1<x0 the two values SHALL be swapped (likewise y0/y1), and any bound >= H_RES (or >= V_RES) SHALL be clamped to H_RES-1 (or V_RES-1).
REQ-030 init_data SHALL be registered and present the word for the current index one cycle after entering a state or after wr_done; it SHALL be 9'h000 outside CMD, WINDOW and PIXEL.
REQ-031 en_write SHALL be 1 exactly in CMD, WINDOW and PIXEL.
REQ-032 wr_done outside CMD, WINDOW and PIXEL SHALL be ignored.
REQ-033 fill_done SHALL pulse in the cycle after the last pixel's wr_done, coincident with entry to IDLE.

Reset
REQ-034 On reset assertion, in any state including mid-PIXEL: state=RST_LOW, counters=0, lcd_rst=0, init_data=9'h000, en_write=0, init_done=0, fill_done=0.
REQ-035 After reset release, the full power-on sequence SHALL repeat from the beginning.

Configuration
REQ-036 Macro LCD_WINDOW_FILL_EN: when defined, REQ-027 to REQ-029 and REQ-033 apply.
REQ-037 When LCD_WINDOW_FILL_EN is undefined, ports remain present, fill_req/fill_color/x0..y1 are ignored, fill_done is tied 0, and IDLE is terminal.

Verification (H_RES=4, V_RES=3, T_RST=10, T_WAKE=15, T_SLPOUT=12; writer model pulses wr_done 3 cycles after each new word)
REQ-038 Reset release -> lcd_rst low exactly 10 cycles, then CMD entered after 15 more; first word 0x011, 58th word 0x029.
REQ-039 Power-on fill -> window words 0x02A,0x100,0x100,0x100,0x103,0x02B,0x100,0x100,0x100,0x102,0x02C; then 24 words alternating 0x1FF/0x1FF; then init_done=1 and fill_done=0.
REQ-040 In IDLE, fill_req with x0=1, x1=2, y0=0, y1=0, fill_color=16'hF800 -> 4 pixel words 0x1F8,0x100,0x1F8,0x100; then one fill_done pulse.
REQ-041 fill_req with x0=5, x1=2, y0=2, y1=1 -> latched window (2,1)-(3,2); 8 pixel words issued.
REQ-042 sys_rst asserted at pixel word 10 of a fill -> next cycle lcd_rst=0, en_write=0, init_data=0; full sequence reruns after release.
REQ-043 LCD_WINDOW_FILL_EN undefined, fill_req pulsed in IDLE -> en_write stays 0 and fill_done stays 0.
